bram_port_arbiter: RTL and testbench

//  Shares one simple-dual-port bram (1 write port, 1 registered read port, 1-cycle read latency)

---
 rtl/bram_port_arb_pkg.sv | 26 ++
 rtl/bram_port_arbiter_rr_arbiter.sv | 53 +++++
 rtl/bram_port_arbiter.sv | 103 ++++++++++
 tb/tb_bram_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arb_pkg.sv
// Shared helpers for bram_port_arbiter: ID width, one-hot/index conversion and
// round-robin pointer wrap.
package bram_port_arb_pkg;

  localparam int MAX_REQ = 64;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int onehot_to_idx(input req_vec_t oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int ptr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr_q upward,
// pointer moves to one past the winner. N=1 degenerates to gnt = req.
module rr_arbiter
  import bram_port_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  if (N == 1) begin : g_single
    assign gnt_o     = req_i;
    assign gnt_idx_o = '0;
  end else begin : g_rr
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] k;
    logic          found;
    req_vec_t      gnt_ext;

    always_comb begin
      gnt_o = '0;
      found = 1'b0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
        k = IW'((int'(ptr_q) + i) % N);
        if (!found && req_i[k]) begin
          gnt_o[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end

    always_comb begin
      gnt_ext          = '0;
      gnt_ext[N-1:0]   = gnt_o;
      gnt_idx_o        = IW'(onehot_to_idx(gnt_ext));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ptr_q <= '0;
      end else if (|gnt_o) begin
        ptr_q <= IW'(ptr_wrap(int'(gnt_idx_o), N));
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port bram between N_REQ requesters with independent
// round-robin write/read arbitration. Optional same-cycle RAW bypass: BRAM_PORT_ARB_RAW_BYPASS_EN.
module bram_port_arbiter
  import bram_port_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int BRAM_DEPTH = 1024,
  parameter int BRAM_W     = 64,
  localparam int AW  = $clog2(BRAM_DEPTH),
  localparam int IDW = idw(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      wr_req_i,
  input  logic [N_REQ*AW-1:0]   wr_addr_i,
  input  logic [N_REQ*BRAM_W-1:0] wr_data_i,
  output logic [N_REQ-1:0]      wr_gnt_o,
  input  logic [N_REQ-1:0]      rd_req_i,
  input  logic [N_REQ*AW-1:0]   rd_addr_i,
  output logic [N_REQ-1:0]      rd_gnt_o,
  output logic                  rd_vld_o,
  output logic [IDW-1:0]        rd_id_o,
  output logic [BRAM_W-1:0]     rd_data_o,
  output logic                  bram_wen_o,
  output logic [AW-1:0]         bram_waddr_o,
  output logic [BRAM_W-1:0]     bram_wdata_o,
  output logic [AW-1:0]         bram_raddr_o,
  input  logic [BRAM_W-1:0]     bram_rdata_i
);

  logic [IDW-1:0] wr_idx;
  logic [IDW-1:0] rd_idx;
  logic           rd_vld_p1;
  logic [IDW-1:0] rd_id_p1;

  rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (wr_req_i),
    .gnt_o     (wr_gnt_o),
    .gnt_idx_o (wr_idx)
  );

  rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (rd_req_i),
    .gnt_o     (rd_gnt_o),
    .gnt_idx_o (rd_idx)
  );

  // Stage p0: grant-selected request drives the bram ports
  always_comb begin
    bram_wen_o   = |wr_gnt_o;
    bram_waddr_o = '0;
    bram_wdata_o = '0;
    bram_raddr_o = '0;
    if (|wr_gnt_o) begin
      bram_waddr_o = wr_addr_i[int'(wr_idx)*AW +: AW];
      bram_wdata_o = wr_data_i[int'(wr_idx)*BRAM_W +: BRAM_W];
    end
    if (|rd_gnt_o) begin
      bram_raddr_o = rd_addr_i[int'(rd_idx)*AW +: AW];
    end
  end

  // Stage p1: response tag aligned with the bram's registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1 <= 1'b0;
      rd_id_p1  <= '0;
    end else begin
      rd_vld_p1 <= |rd_gnt_o;
      rd_id_p1  <= rd_idx;
    end
  end

  assign rd_vld_o = rd_vld_p1;
  assign rd_id_o  = rd_id_p1;

`ifdef BRAM_PORT_ARB_RAW_BYPASS_EN
  logic              raw_hit_q;
  logic [BRAM_W-1:0] raw_wdata_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_hit_q <= 1'b0;
    end else begin
      raw_hit_q <= (|wr_gnt_o) && (|rd_gnt_o) && (bram_waddr_o == bram_raddr_o);
    end
  end

  // Data register carries no reset; raw_hit_q alone qualifies it
  always_ff @(posedge clk) begin
    raw_wdata_p1 <= bram_wdata_o;
  end

  assign rd_data_o = raw_hit_q ? raw_wdata_p1 : bram_rdata_i;
`else
  assign rd_data_o = bram_rdata_i;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first bram model attached.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int W  = 64;

  logic           clk;
  logic           rst;
  logic [N-1:0]   wr_req, rd_req;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   wr_gnt, rd_gnt;
  logic           rd_vld;
  logic [1:0]     rd_id;
  logic [W-1:0]   rd_data;
  logic           bram_wen;
  logic [AW-1:0]  bram_waddr, bram_raddr;
  logic [W-1:0]   bram_wdata, bram_rdata;

  logic [AW-1:0]  wa [N];
  logic [AW-1:0]  ra [N];
  logic [W-1:0]   wd [N];
  logic [W-1:0]   mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  wr_req;
    logic [3:0]  rd_req;
    logic [3:0]  exp_wg;
    logic [3:0]  exp_rg;
    logic        exp_vld;
    logic [1:0]  exp_id;
    logic [9:0]  exp_waddr;
  } vec_t;

  vec_t vecs [10];

  bram_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_gnt_o     (wr_gnt),
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
    .rd_gnt_o     (rd_gnt),
    .rd_vld_o     (rd_vld),
    .rd_id_o      (rd_id),
    .rd_data_o    (rd_data),
    .bram_wen_o   (bram_wen),
    .bram_waddr_o (bram_waddr),
    .bram_wdata_o (bram_wdata),
    .bram_raddr_o (bram_raddr),
    .bram_rdata_i (bram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    for (int k = 0; k < N; k++) begin
      wr_addr[k*AW +: AW] = wa[k];
      rd_addr[k*AW +: AW] = ra[k];
      wr_data[k*W +: W]   = wd[k];
    end
  end

  // Read-first simple-dual-port bram, one cycle read latency
  always @(posedge clk) begin
    if (bram_wen) mem[bram_waddr] <= bram_wdata;
    bram_rdata <= mem[bram_raddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_raw;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int k = 0; k < N; k++) begin
      wa[k] = AW'(10 + k);
      ra[k] = AW'(20 + k);
      wd[k] = 64'h100 + 64'(k);
    end
    rst = 1'b1;
    wr_req = '0;
    rd_req = '0;

    vecs[0] = '{4'hF, 4'hF, 4'b0001, 4'b0001, 1'b0, 2'd0, 10'd10};
    vecs[1] = '{4'hF, 4'hF, 4'b0010, 4'b0010, 1'b1, 2'd0, 10'd11};
    vecs[2] = '{4'hF, 4'hF, 4'b0100, 4'b0100, 1'b1, 2'd1, 10'd12};
    vecs[3] = '{4'hF, 4'hF, 4'b1000, 4'b1000, 1'b1, 2'd2, 10'd13};
    vecs[4] = '{4'hF, 4'hF, 4'b0001, 4'b0001, 1'b1, 2'd3, 10'd10};
    vecs[5] = '{4'h0, 4'h0, 4'b0000, 4'b0000, 1'b1, 2'd0, 10'd0};
    vecs[6] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 1'b0, 2'd0, 10'd10};
    vecs[7] = '{4'b0110, 4'b1001, 4'b0010, 4'b0001, 1'b1, 2'd3, 10'd11};
    vecs[8] = '{4'b1001, 4'b0110, 4'b1000, 4'b0010, 1'b1, 2'd0, 10'd13};
    vecs[9] = '{4'hF, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd1, 10'd10};

    // Reset with every request asserted
    repeat (2) @(posedge clk);
    #1;
    wr_req = 4'hF;
    rd_req = 4'hF;
    @(negedge clk);
    chk("reset rd_vld", 64'(rd_vld), 64'd0);
    chk("reset wr_gnt", 64'(wr_gnt), 64'b0001);
    chk("reset rd_gnt", 64'(rd_gnt), 64'b0001);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wr_req = vecs[i].wr_req;
      rd_req = vecs[i].rd_req;
      @(negedge clk);
      chk($sformatf("v%0d wr_gnt", i), 64'(wr_gnt), 64'(vecs[i].exp_wg));
      chk($sformatf("v%0d rd_gnt", i), 64'(rd_gnt), 64'(vecs[i].exp_rg));
      chk($sformatf("v%0d rd_vld", i), 64'(rd_vld), 64'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("v%0d rd_id", i), 64'(rd_id), 64'(vecs[i].exp_id));
      chk($sformatf("v%0d bram_wen", i), 64'(bram_wen), 64'(|vecs[i].exp_wg));
      chk($sformatf("v%0d bram_waddr", i), 64'(bram_waddr), 64'(vecs[i].exp_waddr));
      next_cycle();
    end

    // Lone requester 3 wins immediately, then pointer wraps so req0 beats req1
    wr_req = '0;
    rd_req = 4'b0001;
    @(negedge clk);
    chk("rr5a rd_gnt", 64'(rd_gnt), 64'b0001);
    next_cycle();
    rd_req = 4'b1000;
    @(negedge clk);
    chk("rr5b rd_gnt", 64'(rd_gnt), 64'b1000);
    chk("rr5b rd_id", 64'(rd_id), 64'd0);
    next_cycle();
    rd_req = 4'b0011;
    @(negedge clk);
    chk("rr5c rd_gnt", 64'(rd_gnt), 64'b0001);
    chk("rr5c rd_id", 64'(rd_id), 64'd3);
    next_cycle();
    rd_req = '0;
    @(negedge clk);
    chk("rr5d rd_id", 64'(rd_id), 64'd0);
    next_cycle();

    // Write by req1, later read back by req2
    wa[1] = 10'd5;
    wd[1] = 64'hDEAD;
    wr_req = 4'b0010;
    @(negedge clk);
    chk("wr3 wr_gnt", 64'(wr_gnt), 64'b0010);
    chk("wr3 bram_waddr", 64'(bram_waddr), 64'd5);
    chk("wr3 bram_wdata", bram_wdata, 64'hDEAD);
    next_cycle();
    wr_req = '0;
    ra[2] = 10'd5;
    rd_req = 4'b0100;
    @(negedge clk);
    chk("rd3 rd_gnt", 64'(rd_gnt), 64'b0100);
    chk("rd3 bram_raddr", 64'(bram_raddr), 64'd5);
    next_cycle();
    rd_req = '0;
    @(negedge clk);
    chk("rd3 rd_vld", 64'(rd_vld), 64'd1);
    chk("rd3 rd_id", 64'(rd_id), 64'd2);
    chk("rd3 rd_data", rd_data, 64'hDEAD);
    next_cycle();

    // Same-cycle write and read of address 7
    wa[0] = 10'd7;
    wd[0] = 64'h1234;
    wr_req = 4'b0001;
    @(negedge clk);
    chk("raw pre wr_gnt", 64'(wr_gnt), 64'b0001);
    next_cycle();
    wd[0] = 64'hBEEF;
    ra[1] = 10'd7;
    rd_req = 4'b0010;
    @(negedge clk);
    chk("raw wr_gnt", 64'(wr_gnt), 64'b0001);
    chk("raw rd_gnt", 64'(rd_gnt), 64'b0010);
    chk("raw bram_raddr", 64'(bram_raddr), 64'd7);
    next_cycle();
    wr_req = '0;
    rd_req = '0;
`ifdef BRAM_PORT_ARB_RAW_BYPASS_EN
    exp_raw = 64'hBEEF;
`else
    exp_raw = 64'h1234;
`endif
    @(negedge clk);
    chk("raw rd_vld", 64'(rd_vld), 64'd1);
    chk("raw rd_id", 64'(rd_id), 64'd1);
    chk("raw rd_data", rd_data, exp_raw);
    next_cycle();
    ra[0] = 10'd7;
    rd_req = 4'b0001;
    @(negedge clk);
    chk("raw after rd_gnt", 64'(rd_gnt), 64'b0001);
    next_cycle();
    rd_req = '0;
    @(negedge clk);
    chk("raw after rd_data", rd_data, 64'hBEEF);
    chk("raw after rd_id", 64'(rd_id), 64'd0);
    next_cycle();

    // Reset right behind a read grant drops the response and clears pointers
    wr_req = 4'b0010;
    rd_req = 4'b0100;
    @(negedge clk);
    chk("rst6 rd_gnt", 64'(rd_gnt), 64'b0100);
    chk("rst6 wr_gnt", 64'(wr_gnt), 64'b0010);
    #1;
    rst = 1'b1;
    next_cycle();
    wr_req = 4'hF;
    rd_req = 4'hF;
    @(negedge clk);
    chk("rst6 rd_vld dropped", 64'(rd_vld), 64'd0);
    chk("rst6 wr_gnt in reset", 64'(wr_gnt), 64'b0001);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst6 post rd_gnt", 64'(rd_gnt), 64'b0001);
    chk("rst6 post wr_gnt", 64'(wr_gnt), 64'b0001);
    chk("rst6 post rd_vld", 64'(rd_vld), 64'd0);
    next_cycle();
    rd_req = '0;
    wr_req = '0;
    @(negedge clk);
    chk("rst6 resp rd_vld", 64'(rd_vld), 64'd1);
    chk("rst6 resp rd_id", 64'(rd_id), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
